i2c_addr_xlat_n: RTL and testbench
==================================

# i2c_addr_xlat_n

Parametrised I2C address monitor and channel selector that replaces the fixed two-slave conflict checker. It oversamples a shared SCL/SDA bus on the system clock and decodes START, STOP and the 7-bit address plus R/W byte. It matches the address against a run-time-programmable table of NUM_CH virtual addresses, then drives a per-channel select held for the whole transaction. It flags and counts address conflicts, where more than one enabled entry matches.

## Interface
- NUM_CH, 4: number of downstream channels / table entries (1..16)
- SYNC_STAGES, 2: synchroniser depth on scl_i/sda_i (≥2)
- CNT_W, 8: width of the saturating conflict counter
- clk  in  1  system clock, ≥4× SCL frequency, each SCL phase ≥2 clk
- arst_n  in  1  asynchronous, active-low reset
- scl_i  in  1  bus SCL (asynchronous)
- sda_i  in  1  bus SDA (asynchronous)
- cfg_we  in  1  table write strobe
- cfg_idx  in  $clog2(NUM_CH) (min 1)  entry index
- cfg_vaddr  in  7  address to match for entry
- cfg_en  in  1  entry enable
- ch_sel  out  NUM_CH  one-hot channel select, held until STOP/START
- addr_valid  out  1  one-cycle pulse: address byte decoded
- addr_out  out  7  captured address
- rw_out  out  1  captured R/W bit
- hit  out  1  exactly one entry matched
- conflict  out  1  ≥2 enabled entries matched
- nack  out  1  one-cycle pulse: 9th bit sampled high
- conflict_cnt  out  CNT_W  saturating conflict count
- busy  out  1  state ≠ IDLE

## Operation
- Reset values: every output is 0. Synchroniser flops reset to 1, the idle-bus level. Table entries reset to vaddr=0, en=0.
- Bus events come from the synchronised, registered previous values:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - scl_rise and scl_fall.
- FSM states:
  - IDLE → ADDR on START.
  - ADDR: shift SDA in MSB first on each scl_rise; bit_cnt counts 0..7. On the 8th scl_rise, latch addr_out/rw_out, compute matches, pulse addr_valid, update hit, conflict and ch_sel, then go to ACK.
  - ACK: on the next scl_rise sample SDA. If SDA is 1, pulse nack. In either case go to DATA.
  - DATA: hold all outputs. Data bytes are not decoded.
- Any START in any non-IDLE state is a repeated START:
  - clear ch_sel, hit and conflict;
  - reset bit_cnt;
  - go to ADDR.
- STOP in any state → IDLE and clears ch_sel, hit and conflict. This includes a STOP in the middle of a byte, which aborts the byte: no addr_valid pulse.
- Match rule: entry i matches when en[i]=1 and vaddr[i]==addr_out.
  - Exactly one match: hit=1, ch_sel = that bit.
  - Zero matches: hit=0, ch_sel=0.
  - ≥2 matches: conflict=1, hit=0, ch_sel=0 (no channel forwarded), and conflict_cnt increments, saturating at 2^CNT_W−1.
- Table writes are accepted in any state.
  - Matching uses the table contents in the cycle of the 8th scl_rise.
  - A write in that same cycle is not visible to that match.
  - A write with cfg_idx ≥ NUM_CH is ignored.
- conflict_cnt clears only on reset.

## Timing
- Pin-to-event latency is SYNC_STAGES+1 clk cycles.
- addr_valid is high for exactly one cycle, SYNC_STAGES+1 cycles after the 8th SCL rising edge at the pin.
- ch_sel, hit, conflict, addr_out and rw_out update in the same cycle as addr_valid.
- nack pulses SYNC_STAGES+1 cycles after the 9th SCL rising edge.
- busy rises SYNC_STAGES+1 cycles after START at the pin. It falls SYNC_STAGES+1 cycles after STOP.
- A simultaneous START and scl_rise cannot occur, since SCL is high during START. If SCL and SDA change in the same sample, the SCL change is evaluated first, so no START/STOP is seen.
- Reset mid-transfer forces IDLE immediately, asynchronously. After reset is released, the block waits for a new START.

## Structure
- Package i2c_xlat_pkg contains:
  - the state enum (IDLE, ADDR, ACK, DATA);
  - constant I2C_ADDR_W=7;
  - struct xlat_entry_t {vaddr[6:0], en}.
- Sub-module i2c_bus_sync_edge contains the SYNC_STAGES synchroniser plus detection of scl_rise, scl_fall, START and STOP. It is reused by later bus-side blocks.
- The top level holds the FSM, shift register, bit_cnt, table and counter.

## Test plan
- Table ch0=0x48, ch1=0x4F, both enabled. Write to 0x48 → addr_valid pulses once, addr_out=0x48, rw_out=0, ch_sel=0b0001, hit=1. ch_sel stays held through the data byte and clears at STOP.
- Read from 0x4F → ch_sel=0b0010, rw_out=1. Slave drives ACK low → no nack pulse.
- Conflict: ch0=ch1=0x4F, access 0x4F → conflict=1, ch_sel=0, hit=0, conflict_cnt=1. With CNT_W=2, five conflicting accesses → conflict_cnt saturates at 3.
- Unmatched address 0x20 with no ACK driven → hit=0, ch_sel=0, nack pulses once.
- Repeated START after a 0x48 write, then address 0x4F read → ch_sel goes 0b0001 → 0 → 0b0010. A STOP after 4 address bits → IDLE, with no addr_valid pulse.
- Assert arst_n low during the DATA phase → all outputs 0 asynchronously and table entries disabled. The next transaction to 0x48 without reprogramming the table → hit=0.

Source files
------------

// File: rtl/i2c_xlat_pkg.sv
// Shared types and constants for the I2C address translator and its
// bus-side helper blocks.
package i2c_xlat_pkg;

  localparam int I2C_ADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    ACK  = 2'd2,
    DATA = 2'd3
  } xlat_state_e;

  typedef struct packed {
    logic [I2C_ADDR_W-1:0] vaddr;
    logic                  en;
  } xlat_entry_t;

endpackage

// File: rtl/i2c_addr_xlat_n_if.sv
// Bus-pin, table-programming and status signals of i2c_addr_xlat_n.
interface i2c_addr_xlat_n_if
  import i2c_xlat_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  scl_i;
  logic                  sda_i;
  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_idx;
  logic [I2C_ADDR_W-1:0] cfg_vaddr;
  logic                  cfg_en;
  logic [NUM_CH-1:0]     ch_sel;
  logic                  addr_valid;
  logic [I2C_ADDR_W-1:0] addr_out;
  logic                  rw_out;
  logic                  hit;
  logic                  conflict;
  logic                  nack;
  logic [CNT_W-1:0]      conflict_cnt;
  logic                  busy;

  modport slave (
    input  scl_i, sda_i, cfg_we, cfg_idx, cfg_vaddr, cfg_en,
    output ch_sel, addr_valid, addr_out, rw_out, hit, conflict, nack,
           conflict_cnt, busy
  );

  modport master (
    output scl_i, sda_i, cfg_we, cfg_idx, cfg_vaddr, cfg_en,
    input  ch_sel, addr_valid, addr_out, rw_out, hit, conflict, nack,
           conflict_cnt, busy
  );

endinterface

// File: rtl/i2c_bus_sync_edge.sv
// Synchronises asynchronous SCL/SDA onto clk and derives SCL edges plus
// START/STOP conditions from the synchronised and previous samples.
module i2c_bus_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl;

  // NOTE: flops are written with <= so every stage samples the value from
  // before the edge; blocking '=' would collapse the chain into one stage.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  // SCL must be high in both samples, so an SCL change masks any SDA edge.
  assign start = scl & scl_prev & sda_prev & ~sda;
  assign stop  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_addr_xlat_n.sv
// I2C address monitor: decodes the address byte, matches it against a
// programmable table and drives a one-hot channel select per transaction.
module i2c_addr_xlat_n
  import i2c_xlat_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  i2c_addr_xlat_n_if.slave  bus
);

  logic sda, scl_rise, scl_fall_unused, start, stop;

  i2c_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .arst_n   (arst_n),
    .scl_pin  (bus.scl_i),
    .sda_pin  (bus.sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall_unused),
    .start    (start),
    .stop     (stop)
  );

  xlat_state_e           state, state_nxt;
  logic [2:0]            bit_cnt;
  logic [I2C_ADDR_W-1:0] shift_q;
  logic [I2C_ADDR_W-1:0] addr_q;
  logic                  rw_q;
  logic                  addr_valid_q;
  logic                  nack_q;
  logic [NUM_CH-1:0]     ch_sel_q;
  logic                  hit_q;
  logic                  conflict_q;
  logic [CNT_W-1:0]      cnt_q;
  xlat_entry_t           tbl_q [NUM_CH];

  logic clr_sel, clr_bits, shift_en, latch_addr, nack_set;
  logic [NUM_CH-1:0] match;
  logic              multi, one;

  // NOTE: the table is a handful of flops that must come up disabled, so it
  // takes the async reset like any other state rather than being a RAM.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_CH; i++) tbl_q[i] <= '0;
    end else if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_CH)) begin
      tbl_q[bus.cfg_idx] <= '{vaddr: bus.cfg_vaddr, en: bus.cfg_en};
    end
  end

  // During the 8th rise shift_q already holds the seven address bits.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CH; i++)
      match[i] = tbl_q[i].en && (tbl_q[i].vaddr == shift_q);
  end

  assign multi = |(match & (match - NUM_CH'(1)));
  assign one   = (|match) && !multi;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    clr_sel    = 1'b0;
    clr_bits   = 1'b0;
    shift_en   = 1'b0;
    latch_addr = 1'b0;
    nack_set   = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      clr_sel   = 1'b1;
    end else if (start) begin
      state_nxt = ADDR;
      clr_sel   = 1'b1;
      clr_bits  = 1'b1;
    end else if (scl_rise) begin
      case (state)
        ADDR: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            latch_addr = 1'b1;
            state_nxt  = ACK;
          end
        end
        ACK: begin
          nack_set  = sda;
          state_nxt = DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_cnt      <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      addr_valid_q <= 1'b0;
      nack_q       <= 1'b0;
      ch_sel_q     <= '0;
      hit_q        <= 1'b0;
      conflict_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      addr_valid_q <= latch_addr;
      nack_q       <= nack_set;
      if (clr_bits) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift_q <= {shift_q[I2C_ADDR_W-2:0], sda};
      end
      if (latch_addr) begin
        addr_q <= shift_q;
        rw_q   <= sda;
      end
      if (clr_sel) begin
        ch_sel_q   <= '0;
        hit_q      <= 1'b0;
        conflict_q <= 1'b0;
      end else if (latch_addr) begin
        ch_sel_q   <= one ? match : '0;
        hit_q      <= one;
        conflict_q <= multi;
        if (multi && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.ch_sel       = ch_sel_q;
  assign bus.addr_valid   = addr_valid_q;
  assign bus.addr_out     = addr_q;
  assign bus.rw_out       = rw_q;
  assign bus.hit          = hit_q;
  assign bus.conflict     = conflict_q;
  assign bus.nack         = nack_q;
  assign bus.conflict_cnt = cnt_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_i2c_addr_xlat_n.sv
// Scoreboard bench for i2c_addr_xlat_n: a bit-banged I2C master/slave drives
// the bus, a reference model predicts each decoded address byte.
module tb_i2c_addr_xlat_n;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 2;
  localparam int IDX_W       = 2;
  localparam int Q           = 40;

  typedef struct {
    logic [6:0]        addr;
    logic              rw;
    logic [NUM_CH-1:0] ch;
    logic              hit;
    logic              conf;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  logic clk;
  logic arst_n;

  i2c_addr_xlat_n_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  i2c_addr_xlat_n #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                total, bad;
  int                av_seen, av_exp, nack_seen, nack_exp;
  logic [6:0]        m_vaddr [NUM_CH];
  logic              m_en    [NUM_CH];
  logic [CNT_W-1:0]  m_cnt;
  logic [NUM_CH-1:0] last_ch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every addr_valid cycle pops one prediction.
  always @(negedge clk) begin
    if (bus.nack) nack_seen++;
    if (bus.addr_valid) begin
      av_seen++;
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("addr_out", 32'(bus.addr_out), 32'(mon_e.addr));
        check("rw_out", 32'(bus.rw_out), 32'(mon_e.rw));
        check("ch_sel", 32'(bus.ch_sel), 32'(mon_e.ch));
        check("hit", 32'(bus.hit), 32'(mon_e.hit));
        check("conflict", 32'(bus.conflict), 32'(mon_e.conf));
        check("conflict_cnt", 32'(bus.conflict_cnt), 32'(mon_e.cnt));
      end
    end
  end

  task automatic cfg_write(input int idx, input logic [6:0] va, input logic en);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_idx   = IDX_W'(idx);
    bus.cfg_vaddr = va;
    bus.cfg_en    = en;
    m_vaddr[idx]  = va;
    m_en[idx]     = en;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.sda_i = b;
    #Q bus.scl_i = 1'b1;
    #(2*Q) bus.scl_i = 1'b0;
    #Q;
  endtask

  task automatic start_cond();
    bus.sda_i = 1'b1;
    #Q bus.scl_i = 1'b1;
    #Q bus.sda_i = 1'b0;
    #Q bus.scl_i = 1'b0;
    #Q;
  endtask

  task automatic stop_cond();
    bus.sda_i = 1'b0;
    #Q bus.scl_i = 1'b1;
    #Q bus.sda_i = 1'b1;
    #Q;
  endtask

  // Address byte plus ACK slot; the addressed slave ACKs only on a clean hit.
  task automatic addr_phase(input logic [6:0] a, input logic rw);
    exp_t       e;
    int         n, last;
    logic [7:0] byte_v;
    n = 0;
    last = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (m_en[i] && (m_vaddr[i] == a)) begin
        n++;
        last = i;
      end
    e.addr = a;
    e.rw   = rw;
    e.hit  = (n == 1);
    e.conf = (n >= 2);
    e.ch   = (n == 1) ? (NUM_CH'(1) << last) : '0;
    if (n >= 2 && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    e.cnt   = m_cnt;
    last_ch = e.ch;
    exp_q.push_back(e);
    av_exp++;
    byte_v = {a, rw};
    for (int i = 7; i >= 0; i--) send_bit(byte_v[i]);
    send_bit(!e.hit);
    if (!e.hit) nack_exp++;
  endtask

  task automatic data_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(1'b0);
  endtask

  task automatic end_txn(input string tag);
    stop_cond();
    #50;
    check({tag, "_sel_idle"}, 32'(bus.ch_sel), 32'd0);
    check({tag, "_hit_idle"}, 32'(bus.hit), 32'd0);
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_av_cnt"}, 32'(av_seen), 32'(av_exp));
    check({tag, "_nack_cnt"}, 32'(nack_seen), 32'(nack_exp));
  endtask

  initial begin
    total = 0; bad = 0;
    av_seen = 0; av_exp = 0; nack_seen = 0; nack_exp = 0;
    m_cnt = '0; last_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_vaddr[i] = '0;
      m_en[i]    = 1'b0;
    end
    arst_n        = 1'b0;
    bus.scl_i     = 1'b1;
    bus.sda_i     = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_vaddr = '0;
    bus.cfg_en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ch_sel", 32'(bus.ch_sel), 32'd0);
    check("rst_addr_valid", 32'(bus.addr_valid), 32'd0);
    check("rst_addr_out", 32'(bus.addr_out), 32'd0);
    check("rst_hit", 32'(bus.hit), 32'd0);
    check("rst_conflict", 32'(bus.conflict), 32'd0);
    check("rst_nack", 32'(bus.nack), 32'd0);
    check("rst_cnt", 32'(bus.conflict_cnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);

    cfg_write(0, 7'h48, 1'b1);
    cfg_write(1, 7'h4F, 1'b1);

    // Write to 0x48; select must hold through the data byte.
    start_cond();
    check("w48_busy", 32'(bus.busy), 32'd1);
    addr_phase(7'h48, 1'b0);
    data_byte(8'hA5);
    check("w48_hold_sel", 32'(bus.ch_sel), 32'(last_ch));
    check("w48_hold_hit", 32'(bus.hit), 32'd1);
    end_txn("w48");

    // Read from 0x4F, slave ACKs.
    start_cond();
    addr_phase(7'h4F, 1'b1);
    data_byte(8'h3C);
    check("r4f_hold_sel", 32'(bus.ch_sel), 32'h2);
    end_txn("r4f");

    // Unmatched address, nobody ACKs.
    start_cond();
    addr_phase(7'h20, 1'b0);
    end_txn("u20");

    // Repeated START: 0x48 write then 0x4F read.
    start_cond();
    addr_phase(7'h48, 1'b0);
    data_byte(8'h11);
    check("rs_sel_first", 32'(bus.ch_sel), 32'h1);
    start_cond();
    check("rs_sel_clear", 32'(bus.ch_sel), 32'd0);
    check("rs_busy", 32'(bus.busy), 32'd1);
    addr_phase(7'h4F, 1'b1);
    check("rs_sel_second", 32'(bus.ch_sel), 32'h2);
    end_txn("rs");

    // STOP after four address bits aborts the byte.
    start_cond();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    end_txn("abort");

    // Two entries on 0x4F: counter saturates at 3 after five conflicts.
    cfg_write(0, 7'h4F, 1'b1);
    for (int k = 0; k < 5; k++) begin
      start_cond();
      addr_phase(7'h4F, 1'b0);
      end_txn("conf");
    end

    // Reset in the data phase, then the table must be empty.
    cfg_write(0, 7'h48, 1'b1);
    start_cond();
    addr_phase(7'h48, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    arst_n = 1'b0;
    #1;
    check("arst_ch_sel", 32'(bus.ch_sel), 32'd0);
    check("arst_hit", 32'(bus.hit), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_cnt", 32'(bus.conflict_cnt), 32'd0);
    check("arst_addr_out", 32'(bus.addr_out), 32'd0);
    for (int i = 0; i < NUM_CH; i++) begin
      m_vaddr[i] = '0;
      m_en[i]    = 1'b0;
    end
    m_cnt = '0;
    #9;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    send_bit(1'b0);
    end_txn("arst_tail");

    start_cond();
    addr_phase(7'h48, 1'b0);
    end_txn("post_rst");

    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
